// File: rtl/rename_pkg.sv
// Shared types and default sizes for the register-rename stage.
package rename_pkg;

    localparam int DEF_ARCH_REGS = 32;
    localparam int DEF_PHYS_REGS = 64;
    localparam int AREG_BITS     = $clog2(DEF_ARCH_REGS);
    localparam int PREG_BITS     = $clog2(DEF_PHYS_REGS);

    typedef logic [AREG_BITS-1:0] areg_t;
    typedef logic [PREG_BITS-1:0] preg_t;

    typedef struct packed {
        preg_t prd;
        preg_t prs1;
        preg_t prs2;
        preg_t old_prd;
        logic  rd_wr;
    } renamed_t;

endpackage

// File: rtl/rename_map_if.sv
// Decode-side, dispatch-side and retire/flush signals of the rename stage.
interface rename_map_if
    import rename_pkg::*;
#(
    parameter int AREG_W = AREG_BITS,
    parameter int PREG_W = PREG_BITS
);
    logic              in_valid;
    logic              in_ready;
    logic [AREG_W-1:0] in_rd;
    logic [AREG_W-1:0] in_rs1;
    logic [AREG_W-1:0] in_rs2;
    logic              in_rd_wr;

    logic              out_valid;
    logic              out_ready;
    logic [PREG_W-1:0] out_prd;
    logic [PREG_W-1:0] out_prs1;
    logic [PREG_W-1:0] out_prs2;
    logic [PREG_W-1:0] out_old_prd;
    logic              out_rd_wr;

    logic              retire_valid;
    logic              retire_rd_wr;
    logic [AREG_W-1:0] retire_arch_rd;
    logic [PREG_W-1:0] retire_prd;
    logic [PREG_W-1:0] retire_old_prd;

    logic              flush;
    logic [PREG_W:0]   free_count;

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_rd_wr, out_ready,
               retire_valid, retire_rd_wr, retire_arch_rd, retire_prd, retire_old_prd, flush,
        input  in_ready, out_valid, out_prd, out_prs1, out_prs2, out_old_prd, out_rd_wr,
               free_count
    );

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_rd_wr, out_ready,
               retire_valid, retire_rd_wr, retire_arch_rd, retire_prd, retire_old_prd, flush,
        output in_ready, out_valid, out_prd, out_prs1, out_prs2, out_old_prd, out_rd_wr,
               free_count
    );

endinterface

// File: rtl/rename_free_fifo.sv
// Circular free list of physical tags; preloaded with ARCH_REGS..PHYS_REGS-1,
// restore snaps head back to the (post-push) tail and marks the list full.
module rename_free_fifo
    import rename_pkg::*;
#(
    parameter  int ARCH_REGS = DEF_ARCH_REGS,
    parameter  int PHYS_REGS = DEF_PHYS_REGS,
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS,
    localparam int PTR_W     = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1,
    localparam int CNT_W     = $clog2(PHYS_REGS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pop,
    output preg_t            pop_tag,
    input  logic             push,
    input  preg_t            push_tag,
    input  logic             restore,
    output logic [CNT_W-1:0] count
);

    preg_t            store [FL_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_next;

    // Depth need not be a power of two, so wrap by compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_tag   = store[head];
    assign tail_next = push ? ptr_inc(tail) : tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                store[i] <= preg_t'(ARCH_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(FL_DEPTH);
        end else begin
            if (push) begin
                store[tail] <= push_tag;
            end
            tail <= tail_next;
            if (restore) begin
                head  <= tail_next;
                count <= CNT_W'(FL_DEPTH);
            end else begin
                if (pop) begin
                    head <= ptr_inc(head);
                end
                count <= count - CNT_W'(pop) + CNT_W'(push);
            end
        end
    end

endmodule

// File: rtl/rename_map.sv
// Register-rename stage: RAT lookup, free-list allocation, retire reclaim.
// RENAME_FLUSH_EN builds the committed table (RRAT) and single-cycle flush recovery.
module rename_map
    import rename_pkg::*;
#(
    parameter  int ARCH_REGS = DEF_ARCH_REGS,
    parameter  int PHYS_REGS = DEF_PHYS_REGS,
    localparam int AREG_W    = $clog2(ARCH_REGS),
    localparam int PREG_W    = $clog2(PHYS_REGS)
) (
    input logic         clk,
    input logic         reset,
    rename_map_if.slave bus
);

    logic            flush_eff;
    logic            alloc_req;
    logic            in_ready;
    logic            accept;
    logic            pop;
    logic            push;
    preg_t           pop_tag;
    logic [PREG_W:0] free_count;
    preg_t           rat [ARCH_REGS];
    renamed_t        out_q;
    logic            out_valid_q;

    assign alloc_req = bus.in_rd_wr && (bus.in_rd != AREG_W'(0));
    assign in_ready  = (!out_valid_q || bus.out_ready) && !flush_eff &&
                       (!alloc_req || free_count != '0);
    assign accept    = bus.in_valid && in_ready;
    assign pop       = accept && alloc_req;

`ifdef RENAME_FLUSH_EN
    preg_t rrat      [ARCH_REGS];
    preg_t rrat_next [ARCH_REGS];

    assign flush_eff = bus.flush;
    assign push      = bus.retire_valid && bus.retire_rd_wr && (bus.retire_arch_rd != AREG_W'(0));

    // Flush restores from the committed table including this cycle's retire.
    always_comb begin
        rrat_next = rrat;
        if (push) begin
            rrat_next[bus.retire_arch_rd] = bus.retire_prd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rrat[i] <= preg_t'(i);
            end
        end else begin
            rrat <= rrat_next;
        end
    end
`else
    logic unused_flush_inputs;

    assign flush_eff           = 1'b0;
    assign push                = bus.retire_valid && bus.retire_rd_wr;
    assign unused_flush_inputs = ^{bus.flush, bus.retire_prd, bus.retire_arch_rd};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i] <= preg_t'(i);
            end
`ifdef RENAME_FLUSH_EN
        end else if (flush_eff) begin
            rat <= rrat_next;
`endif
        end else if (pop) begin
            rat[bus.in_rd] <= pop_tag;
        end
    end

    // Output register reads the pre-edge RAT; the RAT write lands on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush_eff) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_q.prs1    <= rat[bus.in_rs1];
            out_q.prs2    <= rat[bus.in_rs2];
            out_q.old_prd <= rat[bus.in_rd];
            out_q.prd     <= alloc_req ? pop_tag : '0;
            out_q.rd_wr   <= alloc_req;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    rename_free_fifo #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_fifo (
        .clk      (clk),
        .reset    (reset),
        .pop      (pop),
        .pop_tag  (pop_tag),
        .push     (push),
        .push_tag (bus.retire_old_prd),
        .restore  (flush_eff),
        .count    (free_count)
    );

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_prd     = out_q.prd;
    assign bus.out_prs1    = out_q.prs1;
    assign bus.out_prs2    = out_q.prs2;
    assign bus.out_old_prd = out_q.old_prd;
    assign bus.out_rd_wr   = out_q.rd_wr;
    assign bus.free_count  = free_count;

endmodule

// File: tb/tb_rename_map.sv
// Randomised bench for rename_map against a queue-based free-list / map-table model.
module tb_rename_map;
    import rename_pkg::*;

    localparam int NA  = 32;
    localparam int NP  = 64;
    localparam int FLD = NP - NA;
`ifdef RENAME_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef struct {
        int rd;
        int prd;
        int old_prd;
        bit wr;
    } rob_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rename_map_if #(.AREG_W(AREG_BITS), .PREG_W(PREG_BITS)) bus ();

    rename_map dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: speculative free list fl, committed free list cfl (state as if
    // every unretired instruction vanished), in-order queue of dispatched work.
    int   m_rat  [NA];
    int   m_rrat [NA];
    int   fl  [$];
    int   cfl [$];
    rob_t rob [$];
    bit   m_valid;
    int   m_prd, m_prs1, m_prs2, m_old, m_rd;
    bit   m_wr;
    bit   ret_en;

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_rat[i]  = i;
            m_rrat[i] = i;
        end
        fl.delete();
        cfl.delete();
        for (int i = NA; i < NP; i++) begin
            fl.push_back(i);
            cfl.push_back(i);
        end
        rob.delete();
        m_valid = 0;
        m_prd = 0; m_prs1 = 0; m_prs2 = 0; m_old = 0; m_rd = 0; m_wr = 0;
    endtask

    task automatic drive_idle();
        bus.in_valid       = 0;
        bus.in_rd          = '0;
        bus.in_rs1         = '0;
        bus.in_rs2         = '0;
        bus.in_rd_wr       = 0;
        bus.out_ready      = 1;
        bus.retire_valid   = 0;
        bus.retire_rd_wr   = 0;
        bus.retire_arch_rd = '0;
        bus.retire_prd     = '0;
        bus.retire_old_prd = '0;
        bus.flush          = 0;
        ret_en             = 0;
    endtask

    task automatic set_in(input bit v, input int rd, input int rs1, input int rs2, input bit wr);
        bus.in_valid = v;
        bus.in_rd    = areg_t'(rd);
        bus.in_rs1   = areg_t'(rs1);
        bus.in_rs2   = areg_t'(rs2);
        bus.in_rd_wr = wr;
    endtask

    task automatic cycle();
        bit   alloc, exp_ready, acc, fl_now;
        rob_t r;
        rob_t d;
        if (ret_en && rob.size() > 0) begin
            r = rob[0];
            bus.retire_valid   = 1;
            bus.retire_rd_wr   = r.wr;
            bus.retire_arch_rd = areg_t'(r.rd);
            bus.retire_prd     = preg_t'(r.prd);
            bus.retire_old_prd = preg_t'(r.old_prd);
        end else begin
            bus.retire_valid = 0;
            bus.retire_rd_wr = 0;
        end
        #1;
        alloc     = bus.in_rd_wr && (bus.in_rd != 0);
        fl_now    = FLUSH_EN && bus.flush;
        exp_ready = (!m_valid || bus.out_ready) && !fl_now && (!alloc || fl.size() != 0);
        check("in_ready", bus.in_ready, exp_ready);
        acc = bus.in_valid && exp_ready;

        if (bus.retire_valid) begin
            r = rob.pop_front();
            if (r.wr) begin
                fl.push_back(r.old_prd);
                void'(cfl.pop_front());
                cfl.push_back(r.old_prd);
                m_rrat[r.rd] = r.prd;
            end
        end
        if (m_valid && bus.out_ready) begin
            d.rd = m_rd; d.prd = m_prd; d.old_prd = m_old; d.wr = m_wr;
            rob.push_back(d);
        end
        if (fl_now) begin
            m_rat   = m_rrat;
            fl      = cfl;
            rob.delete();
            m_valid = 0;
        end else if (acc) begin
            m_prs1 = m_rat[bus.in_rs1];
            m_prs2 = m_rat[bus.in_rs2];
            m_old  = m_rat[bus.in_rd];
            m_rd   = int'(bus.in_rd);
            m_wr   = alloc;
            if (alloc) begin
                m_prd = fl.pop_front();
                m_rat[bus.in_rd] = m_prd;
            end else begin
                m_prd = 0;
            end
            m_valid = 1;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, m_valid);
        if (m_valid) begin
            check("out_prd", bus.out_prd, m_prd);
            check("out_prs1", bus.out_prs1, m_prs1);
            check("out_prs2", bus.out_prs2, m_prs2);
            check("out_old_prd", bus.out_old_prd, m_old);
            check("out_rd_wr", bus.out_rd_wr, m_wr);
        end
        check("free_count", bus.free_count, fl.size());
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_free_count", bus.free_count, FLD);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    initial begin
        drive_idle();
        model_reset();
        reset = 1;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_prd", bus.out_prd, 0);
        check("rst_out_prs1", bus.out_prs1, 0);
        check("rst_out_old", bus.out_old_prd, 0);
        check("rst_out_rd_wr", bus.out_rd_wr, 0);
        check("rst_free_count", bus.free_count, FLD);
        @(posedge clk);
        #1;
        reset = 0;

        // rd=0 never allocates; then basic rename and RAT forwarding
        set_in(1, 0, 0, 0, 1); cycle();
        check("rd0_rd_wr", bus.out_rd_wr, 0);
        check("rd0_prd", bus.out_prd, 0);
        check("rd0_free", bus.free_count, 32);
        set_in(1, 5, 5, 0, 1); cycle();
        check("first_prd", bus.out_prd, 32);
        check("first_old", bus.out_old_prd, 5);
        check("first_prs1", bus.out_prs1, 5);
        check("first_prs2", bus.out_prs2, 0);
        set_in(1, 5, 5, 0, 1); cycle();
        check("second_prs1", bus.out_prs1, 32);

        // exhaust the free list, then recycle one tag
        do_reset();
        for (int i = 0; i < FLD; i++) begin
            set_in(1, ((i + 6) % 31) + 1, i % NA, 0, 1);
            cycle();
        end
        check("empty_free", bus.free_count, 0);
        set_in(1, 9, 1, 2, 1); #1;
        check("empty_ready", bus.in_ready, 0);
        cycle();
        set_in(1, 9, 1, 2, 0); #1;
        check("empty_nowr_ready", bus.in_ready, 1);
        cycle();
        set_in(0, 0, 0, 0, 0); ret_en = 1; cycle(); ret_en = 0;
        set_in(1, 10, 0, 0, 1); cycle();
        check("recycled_prd", bus.out_prd, 7);

        // back-pressure holds the output register
        do_reset();
        set_in(1, 3, 1, 2, 1); cycle();
        bus.out_ready = 0;
        set_in(1, 4, 3, 0, 1); #1;
        check("stall_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("stall_prd", bus.out_prd, 32);
        bus.out_ready = 1;
        cycle();
        check("after_stall_prs1", bus.out_prs1, 32);
        check("after_stall_prd", bus.out_prd, 33);

        // three allocations, retire one, flush
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_in(1, i, 0, 0, 1);
            cycle();
        end
        set_in(0, 0, 0, 0, 0); cycle();
        ret_en = 1; cycle(); ret_en = 0;
        bus.flush = 1; cycle(); bus.flush = 0;
`ifdef RENAME_FLUSH_EN
        check("flush_free", bus.free_count, 32);
        check("flush_valid", bus.out_valid, 0);
`endif
        set_in(1, 3, 1, 2, 1); cycle();
`ifdef RENAME_FLUSH_EN
        check("flush_rat1", bus.out_prs1, 32);
        check("flush_rat2", bus.out_prs2, 2);
        check("flush_rat3", bus.out_old_prd, 3);
        check("flush_next_prd", bus.out_prd, 33);
`endif

        // flush and retire on the same edge
        do_reset();
        set_in(1, 4, 0, 0, 1); cycle();
        set_in(0, 0, 0, 0, 0); cycle();
        ret_en = 1; bus.flush = 1; cycle(); ret_en = 0; bus.flush = 0;
        set_in(1, 5, 4, 0, 1); cycle();
`ifdef RENAME_FLUSH_EN
        check("flush_ret_rat", bus.out_prs1, 32);
        check("flush_ret_prd", bus.out_prd, 33);
`endif

        // randomised traffic with a mid-run reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            set_in(($urandom % 4) != 0,
                   (($urandom % 8) == 0) ? 0 : int'($urandom % NA),
                   int'($urandom % NA), int'($urandom % NA),
                   ($urandom % 4) != 0);
            bus.out_ready = ($urandom % 4) != 0;
            ret_en        = ($urandom % 2) != 0;
            bus.flush     = ($urandom % 40) == 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rename_map.md
# rename_map

Parametrised register-rename stage with a FIFO free list, valid/ready handshakes, a committed (retirement) alias table and single-cycle flush recovery. It sits between decode and dispatch and renames one instruction per cycle. It returns freed physical registers at retire. An instruction that writes arch register 0 never allocates a physical register.

## Interface
- ARCH_REGS, 32, number of architectural registers (power of 2)
- PHYS_REGS, 64, number of physical registers (> ARCH_REGS)
- AREG_W, $clog2(ARCH_REGS), architectural tag width
- PREG_W, $clog2(PHYS_REGS), physical tag width
- FL_DEPTH, PHYS_REGS-ARCH_REGS, free-list FIFO depth (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  rename accepts this cycle
- in_rd, in_rs1, in_rs2  in  AREG_W  architectural tags
- in_rd_wr  in  1  instruction writes rd
- out_valid  out  1  renamed instruction held
- out_ready  in  1  dispatch consumes
- out_prd, out_prs1, out_prs2, out_old_prd  out  PREG_W  physical tags
- out_rd_wr  out  1  allocation was made
- retire_valid  in  1  one instruction retires
- retire_rd_wr  in  1  retiring instruction wrote rd
- retire_arch_rd  in  AREG_W  its architectural destination
- retire_prd, retire_old_prd  in  PREG_W  its new and old mappings
- flush  in  1  discard all unretired work
- free_count  out  PREG_W+1  free-list occupancy

## Operation
- Reset state:
  - RAT[i] = i and RRAT[i] = i.
  - The free-list FIFO holds tags ARCH_REGS..PHYS_REGS-1 in order, with head = tail = 0.
  - free_count = FL_DEPTH.
  - out_valid = 0 and all other outputs are 0.
- alloc_req = in_rd_wr && in_rd != 0.
- in_ready = (!out_valid || out_ready) && !flush && (!alloc_req || free_count != 0). It is combinational in the in_* inputs.
- Accept (in_valid && in_ready):
  - Output register loads prs1 = RAT[in_rs1], prs2 = RAT[in_rs2], old_prd = RAT[in_rd].
  - If alloc_req: prd = FIFO[head], head++, RAT[in_rd] <= prd, out_rd_wr = 1.
  - Otherwise: prd = 0 and out_rd_wr = 0.
- No RAT bypass is needed. The output register and the RAT update on the same edge, so the next instruction sees the new mapping.
- out_valid clears on out_ready when nothing new is accepted.
- Retire (retire_valid && retire_rd_wr && retire_arch_rd != 0):
  - FIFO[tail] <= retire_old_prd and tail++.
  - RRAT[retire_arch_rd] <= retire_prd.
  - Other retires are ignored.
- free_count' = free_count - alloc + free. A retire in the same cycle cannot satisfy an allocation at free_count 0; in_ready is already low.
- Flush (highest priority over accept):
  - RAT <= RRAT, with a same-cycle retire's RRAT write applied.
  - head <= tail, post-retire.
  - free_count <= FL_DEPTH.
  - out_valid <= 0.
  - Invariant: tail equals the committed head, so every unretired allocation is reclaimed in one cycle.
- Pointers wrap modulo FL_DEPTH. FL_DEPTH need not be a power of 2; wrap uses explicit compare.
- Reset asserted mid-operation restores the full reset state immediately.

## Timing
- Rename latency is 1 cycle from accept to out_valid.
- Sustained throughput is 1 per cycle while out_ready = 1 and the free list is non-empty.
- A retire-freed tag is allocatable on the following cycle.
- Flush takes effect on the edge it is sampled. in_ready is low during the flush cycle, and renaming resumes the next cycle with the restored RAT.

## Configuration
- RENAME_FLUSH_EN defined:
  - RRAT and the flush port logic are built as described.
- RENAME_FLUSH_EN undefined:
  - No RRAT is built, and flush is ignored (treated as 0).
  - retire_prd and retire_arch_rd are unused.
  - Retire only pushes retire_old_prd.

## Structure
- Shared package rename_pkg holds:
  - ARCH_REGS and PHYS_REGS defaults.
  - The preg_t and areg_t typedefs.
  - The renamed-instruction struct (prd, prs1, prs2, old_prd, rd_wr).
- One natural sub-module, rename_free_fifo, holds:
  - The circular tag store, head/tail/count, and the reset preload.
  - A pop port, a push port, and a flush-restore input.

## Test plan
- Reset, then rename rd=5/rs1=5/rs2=0 with wr=1 -> out_prd=32, old_prd=5, prs1=5, prs2=0. The next rd=5 read gives prs1=32.
- Rename rd=0 with wr=1 -> out_rd_wr=0, out_prd=0, free_count unchanged at 32.
- Do 32 allocating renames with no retire -> free_count=0 and in_ready=0 for an allocating instruction. A non-writing instruction is still accepted. One retire with old_prd=7 -> next allocation gets 7.
- Hold out_ready=0 with out_valid=1 -> in_ready=0, and output tags stay stable until out_ready=1.
- Make 3 allocations (rd=1,2,3 -> 32,33,34), retire the first, then flush -> RAT[1]=32, RAT[2]=2, RAT[3]=3, free_count=32, out_valid=0, and the next allocation returns 33.
- Assert flush and retire in the same cycle -> the retired mapping is visible in RAT after the flush.
